// File: rtl/qspi_psram_pkg.sv
// rtl/qspi_psram_pkg.sv - shared states, command codes and timing constants for qspi_psram
// Contents: state_t FSM encoding, CMD_* opcodes, DUMMY_CYCLES, ADDR_NIBBLES.
package qspi_psram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RDATA,
    WDATA
  } state_t;

  localparam logic [7:0] CMD_QWRITE    = 8'h38;
  localparam logic [7:0] CMD_QREAD     = 8'hEB;
  localparam logic [7:0] CMD_QPI_ENTER = 8'h35;
  localparam logic [7:0] CMD_QPI_EXIT  = 8'hF5;

  localparam int DUMMY_CYCLES = 6;
  localparam int ADDR_NIBBLES = 6;

endpackage

// File: rtl/qspi_psram_sync.sv
// rtl/qspi_psram_sync.sv - 2-flop synchronisers for sck/ce_n/dio_in plus sck and ce_n edge detect
// Ports: clk, rst (async, active-high); sck, ce_n, dio_in[3:0] raw pins;
//        sck_rise, sck_fall, ce_fall one-clk pulses; ce_n_s, dio_s[3:0] synchronised levels.
module qspi_psram_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] dio_in,
  output logic       sck_rise,
  output logic       sck_fall,
  output logic       ce_n_s,
  output logic       ce_fall,
  output logic [3:0] dio_s
);

  logic       sck_m, sck_s, sck_d;
  logic       ce_m, ce_d;
  logic [3:0] dio_m;

  // ce_n syncs clear to 0 so a ce_n already low across reset release is not
  // mistaken for a new transaction; a real high-to-low transition is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_m  <= 1'b0;
      sck_s  <= 1'b0;
      sck_d  <= 1'b0;
      ce_m   <= 1'b0;
      ce_n_s <= 1'b0;
      ce_d   <= 1'b0;
      dio_m  <= 4'h0;
      dio_s  <= 4'h0;
    end else begin
      sck_m  <= sck;
      sck_s  <= sck_m;
      sck_d  <= sck_s;
      ce_m   <= ce_n;
      ce_n_s <= ce_m;
      ce_d   <= ce_n_s;
      dio_m  <= dio_in;
      dio_s  <= dio_m;
    end
  end

  // dio_s goes through the same two stages as sck_s, so data is aligned with the edge pulse.
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign ce_fall  = ce_d & ~ce_n_s;

endmodule

// File: rtl/qspi_psram.sv
// rtl/qspi_psram.sv - quad SPI PSRAM slave: serial/QPI command, 24-bit address, quad read/write
// Ports: clk, rst (async, active-high); ce_n, sck, dio_in[3:0] from the host;
//        dio_out[3:0] read data, dio_oe[3:0] drive enable (all ones only in RDATA).
// Parameter: ADDR_BITS - array holds 2^ADDR_BITS bytes, address wraps at the top.
// Macro PSRAM_QPI_MODE_EN: adds the qpi flag (0x35 sets, 0xF5 clears) giving 2-nibble commands.
module qspi_psram
  import qspi_psram_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce_n,
  input  logic       sck,
  input  logic [3:0] dio_in,
  output logic [3:0] dio_out,
  output logic [3:0] dio_oe
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [2:0] ADDR_LAST  = 3'(ADDR_NIBBLES - 1);
  localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_CYCLES - 1);

  logic                 sck_rise, sck_fall, ce_n_s, ce_fall;
  logic [3:0]           dio_s;
  state_t               state, state_nx;
  logic [2:0]           cnt, cnt_last;
  logic [ADDR_BITS-1:0] addr;
  logic [7:0]           cmd_q, cmd_nx;
  logic [3:0]           wnib;
  logic                 nib;
  logic                 qpi;
  logic                 active_rise;
  logic                 mem_we;
  logic [7:0]           mem [DEPTH];

  qspi_psram_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .sck      (sck),
    .ce_n     (ce_n),
    .dio_in   (dio_in),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ce_n_s   (ce_n_s),
    .ce_fall  (ce_fall),
    .dio_s    (dio_s)
  );

  assign active_rise = sck_rise & ~ce_n_s & ~ce_fall;

`ifdef PSRAM_QPI_MODE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qpi <= 1'b0;
    end else if (active_rise && state == CMD && cnt == cnt_last) begin
      if (cmd_nx == CMD_QPI_ENTER) begin
        qpi <= 1'b1;
      end else if (cmd_nx == CMD_QPI_EXIT) begin
        qpi <= 1'b0;
      end
    end
  end
`else
  assign qpi = 1'b0;
`endif

  always_comb begin
    cnt_last = qpi ? 3'd1 : 3'd7;
    cmd_nx   = qpi ? {cmd_q[3:0], dio_s} : {cmd_q[6:0], dio_s[0]};
    mem_we   = active_rise && state == WDATA && nib;
    state_nx = state;
    if (ce_n_s) begin
      state_nx = IDLE;
    end else if (ce_fall) begin
      state_nx = CMD;
    end else if (sck_rise) begin
      case (state)
        CMD: begin
          // Unknown (and mode-change) commands park in IDLE until ce_n rises.
          if (cnt == cnt_last) begin
            state_nx = (cmd_nx == CMD_QWRITE || cmd_nx == CMD_QREAD) ? ADDR : IDLE;
          end
        end
        ADDR: begin
          if (cnt == ADDR_LAST) begin
            state_nx = (cmd_q == CMD_QWRITE) ? WDATA : DUMMY;
          end
        end
        DUMMY: begin
          if (cnt == DUMMY_LAST) begin
            state_nx = RDATA;
          end
        end
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // nib is the nibble phase in both data states: 0 = high nibble next, 1 = low.
  // Clearing it at transaction start is what drops a half-written byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 3'd0;
      addr    <= '0;
      cmd_q   <= 8'h00;
      wnib    <= 4'h0;
      nib     <= 1'b0;
      dio_out <= 4'h0;
    end else if (ce_fall) begin
      cnt   <= 3'd0;
      addr  <= '0;
      cmd_q <= 8'h00;
      wnib  <= 4'h0;
      nib   <= 1'b0;
    end else if (!ce_n_s) begin
      if (sck_rise) begin
        cnt <= (state_nx == state) ? cnt + 3'd1 : 3'd0;
        case (state)
          CMD:  cmd_q <= cmd_nx;
          ADDR: addr  <= ADDR_BITS'({addr, dio_s});
          WDATA: begin
            if (nib) begin
              addr <= addr + ADDR_BITS'(1);
            end else begin
              wnib <= dio_s;
            end
            nib <= ~nib;
          end
          default: ;
        endcase
      end
      if (sck_fall && state == RDATA) begin
        dio_out <= nib ? mem[addr][3:0] : mem[addr][7:4];
        if (nib) begin
          addr <= addr + ADDR_BITS'(1);
        end
        nib <= ~nib;
      end
    end
  end

  // No reset on the array: contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr] <= {wnib, dio_s};
    end
  end

  assign dio_oe = (state == RDATA) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_qspi_psram.sv
// tb/tb_qspi_psram.sv - self-checking bench for qspi_psram against a byte-array host model
module tb_qspi_psram;

  localparam int ADDR_BITS = 12;
  localparam int DEPTH     = 1 << ADDR_BITS;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       ce_n   = 1'b1;
  logic       sck    = 1'b0;
  logic [3:0] dio_in = 4'h0;
  logic [3:0] dio_out;
  logic [3:0] dio_oe;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_mem [DEPTH];
  bit         qpi_m   = 1'b0;
  bit         chk_en  = 1'b0;
  logic [3:0] exp_oe  = 4'h0;
  logic [3:0] exp_out = 4'h0;

  qspi_psram #(.ADDR_BITS(ADDR_BITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .ce_n    (ce_n),
    .sck     (sck),
    .dio_in  (dio_in),
    .dio_out (dio_out),
    .dio_oe  (dio_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Per-cycle compare in the settled low half of each sck period.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle_dio_oe", 32'(dio_oe), 32'(exp_oe));
      if (exp_oe == 4'hF) begin
        check("cycle_dio_out", 32'(dio_out), 32'(exp_out));
      end
    end
  end

  // One sck period: drive data in the low half, compare, then rise and fall.
  task automatic cyc(input logic [3:0] d, input logic [3:0] eo, input logic [3:0] ev,
                     output logic [3:0] got);
    dio_in  = d;
    exp_oe  = eo;
    exp_out = ev;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    got = dio_out;
    @(posedge clk);
    #1 chk_en = 1'b0;
    sck = 1'b1;
    repeat (4) @(posedge clk);
    #1 sck = 1'b0;
  endtask

  task automatic start();
    ce_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic stop();
    ce_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("oe_after_ce_rise", 32'(dio_oe), 32'h0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [7:0] c, input logic [23:0] a);
    logic [3:0] g;
    if (qpi_m) begin
      cyc(c[7:4], 4'h0, 4'h0, g);
      cyc(c[3:0], 4'h0, 4'h0, g);
    end else begin
      for (int i = 7; i >= 0; i--) cyc({3'b000, c[i]}, 4'h0, 4'h0, g);
    end
    if (c == 8'h38 || c == 8'hEB) begin
      for (int i = 5; i >= 0; i--) cyc(a[4*i +: 4], 4'h0, 4'h0, g);
    end
  endtask

  // nibs holds nnib nibbles right-aligned, first-sent nibble most significant.
  task automatic do_write(input logic [23:0] a, input int nnib, input logic [31:0] nibs);
    logic [3:0] g, hi, n;
    int ad;
    ad = int'(a) % DEPTH;
    hi = 4'h0;
    start();
    send_hdr(8'h38, a);
    for (int i = 0; i < nnib; i++) begin
      n = nibs[4*(nnib-1-i) +: 4];
      cyc(n, 4'h0, 4'h0, g);
      if (i % 2 == 0) begin
        hi = n;
      end else begin
        model_mem[ad] = {hi, n};
        ad = (ad + 1) % DEPTH;
      end
    end
    stop();
  endtask

  task automatic do_read(input logic [23:0] a, input int nbytes, output logic [31:0] got);
    logic [3:0] g, h;
    int ad;
    ad  = int'(a) % DEPTH;
    got = 32'h0;
    start();
    send_hdr(8'hEB, a);
    repeat (6) cyc(4'h0, 4'h0, 4'h0, g);
    for (int b = 0; b < nbytes; b++) begin
      cyc(4'h0, 4'hF, model_mem[ad][7:4], h);
      cyc(4'h0, 4'hF, model_mem[ad][3:0], g);
      got = {got[23:0], h, g};
      ad  = (ad + 1) % DEPTH;
    end
    stop();
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  g;

    repeat (3) @(posedge clk);
    #1;
    check("reset_dio_oe", 32'(dio_oe), 32'h0);
    check("reset_dio_out", 32'(dio_out), 32'h0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    do_write(24'h000010, 4, 32'hA53C);
    do_read(24'h000010, 2, r);
    check("write_read_0x10", r, 32'hA53C);

    start();
    send_hdr(8'h00, 24'h0);
    repeat (20) cyc(4'h5, 4'h0, 4'h0, g);
    stop();
    do_read(24'h000010, 2, r);
    check("unknown_cmd_mem_kept", r, 32'hA53C);

    do_write(24'h000020, 2, 32'h11);
    do_write(24'h000020, 1, 32'h7);
    do_read(24'h000020, 1, r);
    check("aborted_write", r, 32'h11);

    do_write(24'h000FFF, 4, 32'hDEAD);
    do_read(24'h000FFF, 1, r);
    check("wrap_at_fff", r, 32'hDE);
    do_read(24'h000000, 1, r);
    check("wrap_at_000", r, 32'hAD);
    do_read(24'h000FFF, 2, r);
    check("wrap_read_stream", r, 32'hDEAD);
    do_read(24'h123010, 1, r);
    check("upper_addr_ignored", r, 32'hA5);

    start();
    send_hdr(8'hEB, 24'h000010);
    repeat (6) cyc(4'h0, 4'h0, 4'h0, g);
    cyc(4'h0, 4'hF, 4'hA, g);
    cyc(4'h0, 4'hF, 4'h5, g);
    repeat (3) @(posedge clk);
    #1 check("pre_reset_dio_out", 32'(dio_out), 32'h3);
    rst = 1'b1;
    #1;
    check("rst_in_read_oe", 32'(dio_oe), 32'h0);
    check("rst_in_read_out", 32'(dio_out), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    qpi_m = 1'b0;
    ce_n  = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    do_read(24'h000010, 1, r);
    check("read_after_reset", r, 32'hA5);

`ifdef PSRAM_QPI_MODE_EN
    start();
    send_hdr(8'h35, 24'h0);
    stop();
    qpi_m = 1'b1;
    do_write(24'h000005, 2, 32'h99);
    do_read(24'h000005, 1, r);
    check("qpi_write_read", r, 32'h99);
    start();
    send_hdr(8'hF5, 24'h0);
    stop();
    qpi_m = 1'b0;
    do_read(24'h000005, 1, r);
    check("qpi_exit_serial_read", r, 32'h99);
`else
    start();
    send_hdr(8'h35, 24'h0);
    stop();
    do_read(24'h000020, 1, r);
    check("no_qpi_serial_read", r, 32'h11);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qspi_psram.md
QSPI_PSRAM -- requirements
Module: qspi_psram

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, giving a byte-addressed array of 2^ADDR_BITS bytes.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all state is clocked on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port ce_n, input, 1 bit: chip enable, active-low.
REQ-005 SHALL have port sck, input, 1 bit: serial clock, sampled in the clk domain.
REQ-006 SHALL have port dio_in, input, 4 bits: serial data in, io3..io0.
REQ-007 SHALL have port dio_out, output, 4 bits: serial data out.
REQ-008 SHALL have port dio_oe, output, 4 bits: per-line output enable, 1 = drive.

Function
REQ-009 SHALL pass sck, ce_n and dio_in through 2-flop synchronisers; clk SHALL be at least 4x the sck frequency.
REQ-010 SHALL detect sck rise and fall edges from the synchronised sck.
- A transaction starts when synchronised ce_n goes low.
- The sck edge counter resets to 0 at transaction start.
REQ-011 SHALL use states IDLE, CMD, ADDR, DUMMY, RDATA and WDATA.
REQ-012 CMD: 8 sck rises, one bit per rise on dio_in[0], MSB first.
REQ-013 ADDR: 6 rises, one nibble per rise on dio_in[3:0], high nibble first.
- Yields a 24-bit address; only the low ADDR_BITS bits are used.
REQ-014 Command 0x38 (quad write): after ADDR, enter WDATA.
- Each pair of rises assembles one byte, high nibble first.
- The byte is written at the current address on the second nibble; the address then increments.
REQ-015 Command 0xEB (quad read): after ADDR, spend 6 rises in DUMMY, then enter RDATA.
- dio_out is updated on the sck fall following each rise from the 6th dummy rise onward.
- Nibbles go out high then low of the byte at the current address; the address increments after each low nibble.
REQ-016 In RDATA dio_oe SHALL be 4'hF; in every other state it SHALL be 4'h0.
REQ-017 Any other command SHALL move to IDLE until ce_n rises, with no memory access and dio_oe = 0.
REQ-018 The address SHALL wrap from 2^ADDR_BITS-1 to 0.
REQ-019 ce_n rising in any state SHALL:
- return the state to IDLE within 3 clk cycles;
- clear dio_oe;
- discard any partially assembled write byte.
REQ-020 sck edges while ce_n is high SHALL be ignored.
REQ-021 Read-after-write to the same address within one clk cycle is not required; separate transactions SHALL see written data.

Reset
REQ-022 rst SHALL asynchronously clear:
- state to IDLE;
- counters, address and shift registers to 0;
- dio_out to 0 and dio_oe to 0.
REQ-023 Memory contents SHALL NOT be cleared by reset.
REQ-024 After reset is released, the first valid transaction SHALL begin on the next synchronised ce_n fall.

Configuration
REQ-025 With macro PSRAM_QPI_MODE_EN defined, command 0x35 SHALL set a qpi flag and command 0xF5 SHALL clear it.
- While qpi is set, CMD SHALL take 2 rises, one nibble each on dio_in[3:0], high first.
- rst SHALL clear qpi.
REQ-026 Without PSRAM_QPI_MODE_EN, 0x35 and 0xF5 SHALL be treated as unknown commands and CMD is always serial.

Structure
REQ-027 A shared package qspi_psram_pkg SHALL hold:
- the state enum;
- command constants CMD_QWRITE = 8'h38, CMD_QREAD = 8'hEB, CMD_QPI_ENTER = 8'h35, CMD_QPI_EXIT = 8'hF5;
- DUMMY_CYCLES = 6.
REQ-028 A single sub-module qspi_psram_sync SHALL provide the synchronisers and sck edge detection; the memory array SHALL be inferred in the top module.

Verification
REQ-029 Write then read:
- Stimulus: write 0x38, address 0x000010, data 0xA5, 0x3C; then read 0xEB, address 0x000010.
- Required response: nibbles A,5,3,C with dio_oe = F only during data.
REQ-030 Unknown command:
- Stimulus: command 0x00 followed by 20 sck clocks.
- Required response: dio_oe stays 0 and memory is unchanged.
REQ-031 Aborted write:
- Stimulus: write to 0x20 with data 0x11; then a new write to 0x20 sending nibble 7, then ce_n high.
- Required response: a read of 0x20 returns 0x11.
REQ-032 Address wrap, with ADDR_BITS = 12:
- Stimulus: write 0x0FFF with data 0xDE, 0xAD.
- Required response: reads give 0xDE at 0xFFF and 0xAD at 0x000.
REQ-033 Reset during read:
- Stimulus: rst pulsed during RDATA.
- Required response: dio_oe = 0 and dio_out = 0 immediately; the next transaction works normally.
REQ-034 QPI mode, with PSRAM_QPI_MODE_EN defined:
- Stimulus: command 0x35, then write 0x38 as two nibbles to address 0x5 with data 0x99.
- Required response: a QPI read 0xEB returns 0x99.
